// File: rtl/data_bus_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : data_bus_ctrl_pkg                                     |
// | Brief    : Shared definitions for the data bus controller:       |
// |            FSM states, access size codes, address map and slave  |
// |            enable levels.                                        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package data_bus_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Access size codes as presented by the MEM stage
    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    // Address map: RAM is [0:IO_BASE-1], IO is [IO_BASE:IO_LIMIT]
    localparam int IO_BASE_DEF  = 1024;
    localparam int IO_LIMIT_DEF = 2047;

    // Chip-enable levels understood by the slaves
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // True when the low address bits break the natural alignment of the size
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_H) begin
            bad = off[0];
        end else if (size == SIZE_W) begin
            bad = (off != 2'b00);
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_ctrl_byte_lane_merge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : data_bus_ctrl_byte_lane_merge                         |
// | Brief    : Big-endian lane logic. Inserts store data into a read |
// |            word and extracts/extends load data from it.          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module data_bus_ctrl_byte_lane_merge
    import data_bus_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Offset 0 is the most significant lane, so the shift counts down with offset
    assign byte_sh  = {~offset_i, 3'b000};
    assign half_sh  = offset_i[1] ? 5'd0 : 5'd16;
    assign byte_val = 8'(word_i >> byte_sh);
    assign half_val = 16'(word_i >> half_sh);

    // Lane insertion for stores and lane extraction for loads
    always_comb begin
        merged_o = word_i;
        load_o   = word_i;
        case (size_i)
            SIZE_B: begin
                merged_o = (word_i & ~(32'h0000_00FF << byte_sh))
                         | ({24'h0, data_i[7:0]} << byte_sh);
                load_o   = uns_i ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            end
            SIZE_H: begin
                merged_o = (word_i & ~(32'h0000_FFFF << half_sh))
                         | ({16'h0, data_i[15:0]} << half_sh);
                load_o   = uns_i ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            end
            SIZE_W: begin
                merged_o = data_i;
                load_o   = word_i;
            end
            default: begin
                merged_o = word_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_bus_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : data_bus_ctrl                                         |
// | Brief    : MEM-stage master for the RAM/IO data bus. Decodes the |
// |            address, sequences read / write / read-modify-write   |
// |            accesses and stalls the pipeline until completion.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BUS_ADDR_W = 11,
    parameter int DATA_W     = 32,
    parameter int IO_BASE    = IO_BASE_DEF,
    parameter int IO_LIMIT   = IO_LIMIT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_uns_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  stall_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  ram_ce_o,
    output logic                  io_ce_o,
    output logic                  bus_we_o,
    output logic [BUS_ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i
);

    localparam logic [ADDR_W-1:0]     IO_LIMIT_A = ADDR_W'(IO_LIMIT);
    localparam logic [BUS_ADDR_W-1:0] IO_BASE_B  = BUS_ADDR_W'(IO_BASE);

    state_t                state_q,   state_d;
    logic [BUS_ADDR_W-1:0] addr_q,    addr_d;
    logic [1:0]            size_q,    size_d;
    logic                  we_q,      we_d;
    logic                  uns_q,     uns_d;
    logic                  err_q,     err_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic [DATA_W-1:0]     rd_word_q, rd_word_d;

    logic                  req_err;
    logic                  io_sel;
    logic [DATA_W-1:0]     merged_word;
    logic [DATA_W-1:0]     load_value;

    // Range uses the full CPU address so 0x800 and above never alias onto the bus
    assign req_err = (req_size_i == SIZE_RSV)
                   || size_misaligned(req_size_i, req_addr_i[1:0])
                   || (req_addr_i > IO_LIMIT_A);

    // Slave select comes only from the latched address
    assign io_sel  = (addr_q >= IO_BASE_B);

    assign stall_o = req_i && !ack_o;

    data_bus_ctrl_byte_lane_merge u_lane (
        .word_i   (rd_word_q),
        .data_i   (wdata_q),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .merged_o (merged_word),
        .load_o   (load_value)
    );

    // State and request latches; reset aborts any access in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            rd_word_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            we_q      <= we_d;
            uns_q     <= uns_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            rd_word_q <= rd_word_d;
        end
    end

    // Next-state sequencing and bus/response outputs decoded from the current state
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        rd_word_d   = rd_word_q;
        ack_o       = 1'b0;
        err_o       = 1'b0;
        rdata_o     = '0;
        ram_ce_o    = DISABLE;
        io_ce_o     = DISABLE;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    addr_d  = req_addr_i[BUS_ADDR_W-1:0];
                    size_d  = req_size_i;
                    we_d    = req_we_i;
                    uns_d   = req_uns_i;
                    wdata_d = req_wdata_i;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we_i && (req_size_i == SIZE_W)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                ram_ce_o   = io_sel ? DISABLE : ENABLE;
                io_ce_o    = io_sel ? ENABLE : DISABLE;
                bus_addr_o = {addr_q[BUS_ADDR_W-1:2], 2'b00};
                rd_word_d  = bus_rdata_i;
                state_d    = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                ram_ce_o    = io_sel ? DISABLE : ENABLE;
                io_ce_o     = io_sel ? ENABLE : DISABLE;
                bus_we_o    = 1'b1;
                bus_addr_o  = {addr_q[BUS_ADDR_W-1:2], 2'b00};
                bus_wdata_o = merged_word;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                ack_o   = 1'b1;
                err_o   = err_q;
                rdata_o = (!we_q && !err_q) ? load_value : '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_data_bus_ctrl                                      |
// | Brief    : Self-checking bench for data_bus_ctrl with a byte-    |
// |            array memory model and a bus-side slave memory.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_data_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, ack, err, ram_ce, io_ce, bus_we;
    logic [31:0] rdata, bus_wdata, bus_rdata;
    logic [10:0] bus_addr;

    int          n_tests = 0;
    int          n_fail = 0;

    // Reference model: flat byte-addressed memory, big-endian
    logic [7:0]  ref_mem [0:2047];
    // Slave side storage seen by the DUT
    logic [31:0] slv_mem [0:511];

    // Expectations shared with the per-cycle checker
    bit          chk_active = 1'b0;
    bit          exp_io = 1'b0;
    logic [10:0] exp_baddr = 11'h0;
    int          ce_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wdata = 32'h0;

    always #5 clk = ~clk;

    data_bus_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_uns_i   (req_uns),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .stall_o     (stall),
        .ack_o       (ack),
        .err_o       (err),
        .rdata_o     (rdata),
        .ram_ce_o    (ram_ce),
        .io_ce_o     (io_ce),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_rdata_i (bus_rdata)
    );

    assign bus_rdata = ((ram_ce || io_ce) && !bus_we) ? slv_mem[bus_addr[10:2]] : 32'h0;

    always @(posedge clk) begin
        if ((ram_ce || io_ce) && bus_we) slv_mem[bus_addr[10:2]] <= bus_wdata;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Per-cycle invariants and bus-side bookkeeping
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall_eq", {31'h0, stall}, {31'h0, (req && !ack)});
            chk("ce_excl", {31'h0, (ram_ce && io_ce)}, 32'h0);
            if (!ack) chk("idle_resp_zero", {err, rdata[30:0]} | {31'h0, rdata[31]}, 32'h0);
            if (ram_ce || io_ce) begin
                ce_cnt++;
                if (chk_active) begin
                    chk("io_sel", {30'h0, io_ce, ram_ce}, exp_io ? 32'h2 : 32'h1);
                    chk("bus_addr", {21'h0, bus_addr}, {21'h0, exp_baddr});
                end
                if (bus_we) begin
                    wr_cnt++;
                    last_wdata = bus_wdata;
                end
            end
        end
    end

    // One access through the DUT, checked against the byte model at ack time
    task automatic access(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit perturb, input bit keep, output logic [31:0] got);
        bit          e_err;
        int          e_lat;
        logic [31:0] e_rd;
        int          a;
        int          lat;
        e_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
                || (addr > 32'd2047);
        e_lat = e_err ? 1 : (we ? ((sz == 2'b10) ? 2 : 3) : 2);
        e_rd  = 32'h0;
        a     = int'(addr[10:0]);
        if (!e_err && !we) begin
            if (sz == 2'b00) e_rd = uns ? {24'h0, ref_mem[a]} : {{24{ref_mem[a][7]}}, ref_mem[a]};
            else if (sz == 2'b01)
                e_rd = uns ? {16'h0, ref_mem[a], ref_mem[a+1]}
                           : {{16{ref_mem[a][7]}}, ref_mem[a], ref_mem[a+1]};
            else e_rd = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
        end

        @(negedge clk);
        if (req) chk("b2b_idle_stall", {30'h0, stall, ack}, 32'h2);
        req = 1'b1; req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
        exp_io = (addr >= 32'd1024); exp_baddr = {addr[10:2], 2'b00}; chk_active = 1'b1;
        @(posedge clk);
        ce_cnt = 0; wr_cnt = 0;
        if (perturb) begin
            #1;
            req = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
            req_size = 2'b11; req_we = ~we; req_uns = ~uns;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        chk("latency", lat, e_lat);
        chk("err", {31'h0, err}, {31'h0, e_err});
        chk("rdata", rdata, e_rd);
        chk("writes", wr_cnt, (we && !e_err) ? 1 : 0);
        if (e_err) chk("err_no_ce", ce_cnt, 0);
        got = we ? last_wdata : rdata;
        if (!keep) req = 1'b0;
        chk_active = 1'b0;
        if (we && !e_err) begin
            if (sz == 2'b00) ref_mem[a] = wd[7:0];
            else if (sz == 2'b01) begin ref_mem[a] = wd[15:8]; ref_mem[a+1] = wd[7:0]; end
            else begin
                ref_mem[a] = wd[31:24]; ref_mem[a+1] = wd[23:16];
                ref_mem[a+2] = wd[15:8]; ref_mem[a+3] = wd[7:0];
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 512; i++) slv_mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ctl", {26'h0, stall, ack, err, ram_ce, io_ce, bus_we}, 32'h0);
        chk("rst_addr", {21'h0, bus_addr}, 32'h0);
        chk("rst_data", bus_wdata | rdata, 32'h0);
        rst_n = 1'b1;

        // Word store / load in IO space
        access(1'b1, 2'b10, 1'b0, 32'd1024, 32'h1234_5678, 1'b0, 1'b0, got);
        chk("st_word_bus", got, 32'h1234_5678);
        access(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0, got);
        chk("ld_word_lit", got, 32'h1234_5678);

        // Byte read-modify-write
        access(1'b1, 2'b00, 1'b0, 32'd1025, 32'h0000_00AB, 1'b0, 1'b0, got);
        chk("rmw_byte_lit", got, 32'h12AB_5678);
        access(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0, got);
        chk("rmw_readback", got, 32'h12AB_5678);

        // Extension cases in RAM
        access(1'b1, 2'b10, 1'b0, 32'd0, 32'h80FF_7F01, 1'b0, 1'b0, got);
        access(1'b0, 2'b00, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, got);
        chk("ld_sbyte_lit", got, 32'hFFFF_FF80);
        access(1'b0, 2'b01, 1'b1, 32'd2, 32'h0, 1'b0, 1'b0, got);
        chk("ld_uhalf_lit", got, 32'h0000_7F01);
        access(1'b0, 2'b01, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, got);
        access(1'b0, 2'b00, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0, got);
        access(1'b0, 2'b00, 1'b0, 32'd1, 32'h0, 1'b0, 1'b0, got);

        // Half store with request dropped and fields scrambled after accept
        access(1'b1, 2'b01, 1'b0, 32'h402, 32'h1234_BEEF, 1'b1, 1'b0, got);
        chk("rmw_half_lit", got, 32'h12AB_BEEF);
        access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0, got);
        access(1'b1, 2'b00, 1'b0, 32'h7FF, 32'h0000_0033, 1'b0, 1'b0, got);
        access(1'b0, 2'b00, 1'b1, 32'h7FF, 32'h0, 1'b0, 1'b0, got);

        // Error cases
        access(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 1'b0, 1'b0, got);
        access(1'b1, 2'b10, 1'b0, 32'h802, 32'hDEAD_BEEF, 1'b0, 1'b0, got);
        access(1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 1'b0, 1'b0, got);
        access(1'b1, 2'b10, 1'b0, 32'h800, 32'hDEAD_BEEF, 1'b0, 1'b0, got);
        access(1'b0, 2'b10, 1'b0, 32'hFFFF_F000, 32'h0, 1'b0, 1'b0, got);
        access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0, 1'b0, got);
        chk("no_alias_lit", got, 32'h80FF_7F01);

        // Reset during the RD phase of a byte store
        access(1'b1, 2'b10, 1'b0, 32'd8, 32'hCAFE_BABE, 1'b0, 1'b0, got);
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0;
        req_addr = 32'd9; req_wdata = 32'h11;
        exp_io = 1'b0; exp_baddr = 11'd8; chk_active = 1'b1;
        @(posedge clk);
        wr_cnt = 0;
        @(negedge clk);
        chk("rst_rd_ce", {31'h0, ram_ce}, 32'h1);
        #2;
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk("rst_async_ctl", {27'h0, ack, err, ram_ce, io_ce, bus_we}, 32'h0);
        chk("rst_async_bus", {21'h0, bus_addr} | bus_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_active = 1'b0;
        chk("rst_no_write", wr_cnt, 0);
        access(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 1'b0, 1'b0, got);
        chk("rst_word_kept", got, 32'hCAFE_BABE);

        // Back-to-back requests with req held high
        access(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1, got);
        access(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1, got);
        access(1'b0, 2'b00, 1'b0, 32'd1025, 32'h0, 1'b0, 1'b0, got);
        chk("b2b_last_lit", got, 32'hFFFF_FFAB);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
